stopwatch_cnt: RTL
==================

STOPWATCH_CNT -- requirements
Module: stopwatch_cnt

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 59, giving the highest minutes value (0..99) before overflow.
REQ-002 The block SHALL have parameter ZERO_BLANK, default 0; when 1, a leading minutes-tens digit of 0 is reported blank.
REQ-003 Port clk, input, 1, single system clock (50 MHz); all logic is on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port i_tick, input, 1, one-cycle pulse at 100 Hz from the upstream NCO; the count advances by 0.01 s per pulse.
REQ-006 Port i_start_stop, input, 1, one-cycle pulse that toggles run/pause.
REQ-007 Port i_clear, input, 1, one-cycle pulse that zeroes the count when not running.
REQ-008 Port i_lap, input, 1, one-cycle pulse that freezes or releases the displayed value.
REQ-009 Port o_digits, output, 24, six BCD nibbles for the downstream 6-digit display: [23:20] min tens, [19:16] min ones, [15:12] sec tens, [11:8] sec ones, [7:4] cs tens, [3:0] cs ones.
REQ-010 Port o_blank, output, 6, per-digit blank flags in the same digit order as o_digits; bit 5 is min tens.
REQ-011 Port o_dp, output, 6, decimal-point enables, equal to 6'b010100 (after min ones and after sec ones).
REQ-012 Port o_running, output, 1, high in state RUN.
REQ-013 Port o_lap, output, 1, high while the display is frozen.
REQ-014 Port o_ovf, output, 1, sticky overflow flag.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-016 On i_start_stop, the FSM SHALL go IDLE->RUN, RUN->PAUSE and PAUSE->RUN; a start pulse in PAUSE while o_ovf=1 SHALL be ignored.
REQ-017 On i_clear in IDLE or PAUSE, the FSM SHALL zero the count, clear o_lap and o_ovf, and go to IDLE; i_clear in RUN SHALL be ignored.
REQ-018 When i_clear and i_start_stop arrive in the same cycle in IDLE or PAUSE, clear SHALL win and the FSM SHALL end in IDLE.
REQ-019 The count SHALL advance only on an i_tick that coincides with the registered state RUN, including the cycle in which i_start_stop moves RUN->PAUSE.
REQ-020 Centiseconds SHALL count 00..99 and carry into seconds; seconds SHALL count 00..59 and carry into minutes; minutes SHALL count 00..MAX_MIN; every digit SHALL be a valid BCD value at all times.
REQ-021 A tick at MAX_MIN:59.99 SHALL hold the count at that value, set o_ovf, and force the FSM to PAUSE.
REQ-022 i_lap in RUN with o_lap=0 SHALL snapshot the running count into o_digits and set o_lap.
REQ-023 While o_lap=1, o_digits SHALL stay frozen while the internal count continues.
REQ-024 i_lap with o_lap=1, in RUN or PAUSE, SHALL clear o_lap so that o_digits tracks the live count again.
REQ-025 i_lap in IDLE, or in PAUSE with o_lap=0, SHALL be ignored.
REQ-026 When o_lap=0, o_digits SHALL reflect a tick one clock after the tick cycle (registered, latency 1).
REQ-027 When ZERO_BLANK=1, o_blank[5] SHALL be 1 whenever the displayed min tens digit is 0; all other o_blank bits SHALL always be 0.
REQ-028 Control pulses held high for more than one cycle SHALL be treated as a new event on every cycle they are high; no edge detection is performed inside the block.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL return to state IDLE with the count at 0 and o_digits=0, o_running=0, o_lap=0 and o_ovf=0.
REQ-030 While rst=1, o_blank SHALL be 6'b100000 if ZERO_BLANK=1 and 0 otherwise, and o_dp SHALL be 6'b010100.
REQ-031 rst SHALL override every other input in the same cycle, including mid-count and mid-lap.

Verification
REQ-032 The bench SHALL cover basic counting: reset, start, then 6123 ticks -> o_digits=24'h01_01_23, o_running=1.
REQ-033 The bench SHALL cover carries: preload the count to 00:59.99 via ticks, apply one tick -> 24'h01_00_00 on the next clock.
REQ-034 The bench SHALL cover lap: in RUN at 00:05.00 pulse i_lap, then apply 300 ticks -> o_digits stays 24'h00_05_00 with o_lap=1; pulse i_lap again -> 24'h00_08_00.
REQ-035 The bench SHALL cover clear priority: i_clear in RUN -> no change; stop, then i_clear together with i_start_stop -> IDLE with o_digits=0.
REQ-036 The bench SHALL cover overflow: with MAX_MIN=0, apply 6000 ticks -> o_digits=24'h00_59_99, o_ovf=1, o_running=0; a start pulse is ignored; i_clear clears o_ovf.
REQ-037 The bench SHALL cover mid-run reset: assert rst for one cycle during RUN with o_lap=1 -> all outputs at their reset values on the next clock.

Source files
------------

// File: rtl/stopwatch_cnt.sv
// Six-digit BCD stopwatch (MM:SS.cc) with run/pause/clear, lap freeze and
// sticky overflow, advanced by an external 100 Hz tick.
module stopwatch_cnt #(
  parameter int unsigned MAX_MIN    = 59,
  parameter bit          ZERO_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_start_stop,
  input  logic        i_clear,
  input  logic        i_lap,
  output logic [23:0] o_digits,
  output logic [5:0]  o_blank,
  output logic [5:0]  o_dp,
  output logic        o_running,
  output logic        o_lap,
  output logic        o_ovf
);

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned NDIG    = 6;
  localparam int unsigned CNT_W   = DIG_W * NDIG;
  localparam logic [DIG_W-1:0] MAX_MT = DIG_W'(MAX_MIN / 10);
  localparam logic [DIG_W-1:0] MAX_MO = DIG_W'(MAX_MIN % 10);
  localparam logic [CNT_W-1:0] CNT_MAX = {MAX_MT, MAX_MO, 4'h5, 4'h9, 4'h9, 4'h9};
  localparam logic [NDIG-1:0]  BLANK_RST = {ZERO_BLANK, 5'b00000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   digits_q, digits_d;
  logic [NDIG-1:0]    blank_q, blank_d;
  logic               running_q, running_d;
  logic               lap_q, lap_d;
  logic               ovf_q, ovf_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               wrap0, wrap1, wrap2, wrap3, wrap4;
  logic               at_max;

  // Advance one digit when enabled, wrapping to zero at its limit.
  function automatic logic [DIG_W-1:0] bump(input logic [DIG_W-1:0] d,
                                            input logic en, input logic wrap);
    if (!en)  return d;
    if (wrap) return '0;
    return d + DIG_W'(1);
  endfunction

  // BCD carry chain: cs ones/tens, sec ones/tens (0..5), min ones/tens.
  always_comb begin
    wrap0 = (cnt_q[3:0]   == 4'h9);
    wrap1 = wrap0 && (cnt_q[7:4]   == 4'h9);
    wrap2 = wrap1 && (cnt_q[11:8]  == 4'h9);
    wrap3 = wrap2 && (cnt_q[15:12] == 4'h5);
    wrap4 = wrap3 && (cnt_q[19:16] == 4'h9);
    cnt_inc[3:0]   = bump(cnt_q[3:0],   1'b1,  wrap0);
    cnt_inc[7:4]   = bump(cnt_q[7:4],   wrap0, wrap1);
    cnt_inc[11:8]  = bump(cnt_q[11:8],  wrap1, wrap2);
    cnt_inc[15:12] = bump(cnt_q[15:12], wrap2, wrap3);
    cnt_inc[19:16] = bump(cnt_q[19:16], wrap3, wrap4);
    cnt_inc[23:20] = bump(cnt_q[23:20], wrap4, 1'b0);
    at_max         = (cnt_q == CNT_MAX);
  end

  // Next-state, count, lap and display logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (i_clear) begin
          cnt_d = '0;
          lap_d = 1'b0;
          ovf_d = 1'b0;
        end else if (i_start_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_start_stop) state_d = PAUSE;
        if (i_lap)        lap_d   = !lap_q;
        if (i_tick) begin
          if (at_max) begin
            ovf_d   = 1'b1;
            state_d = PAUSE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      PAUSE: begin
        if (i_clear) begin
          cnt_d   = '0;
          lap_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end else begin
          if (i_start_stop && !ovf_q) state_d = RUN;
          if (i_lap && lap_q)         lap_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Display holds only while lap stays asserted across the edge.
    digits_d  = (lap_q && lap_d) ? digits_q : cnt_d;
    blank_d   = {ZERO_BLANK && (digits_d[23:20] == 4'h0), 5'b00000};
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      digits_q  <= '0;
      blank_q   <= BLANK_RST;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_digits  = digits_q;
  assign o_blank   = blank_q;
  assign o_dp      = 6'b010100;
  assign o_running = running_q;
  assign o_lap     = lap_q;
  assign o_ovf     = ovf_q;

endmodule
